channel_sequencer: RTL
======================

CHANNEL_SEQUENCER -- requirements
Module: channel_sequencer

Interface
REQ-001 Parameter: none; step-table depth is fixed by the shared package (`CHSEQ_DEPTH` = 16).
REQ-002 clk_50mhz  in  1  sole clock; all logic is on the rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 tick  in  1  one-cycle 8 kHz strobe, already synchronous to clk_50mhz.
REQ-005 start  in  1  one-cycle request to begin playback at step 0.
REQ-006 stop  in  1  one-cycle request to abort playback.
REQ-007 loop_en  in  1  restart at step 0 at pattern end; used only when the loop feature is compiled in.
REQ-008 wr_en, wr_addr, wr_data  in  1/4/24  step-table write port; wr_data = {dur[7:0], pitch[7:0], 2'b00, vol[5:0]}.
REQ-009 wr_ready  out  1  high when writes are accepted.
REQ-010 cfg_reg_1, cfg_reg_2, cfg_reg_4  in  8 each  envelope and panning settings, captured on start.
REQ-011 reg_0, reg_1, reg_2, reg_3, reg_4  out  8 each  channel register image; reg_0 = {1'b0, retrig, vol}.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 step_idx  out  4  index of the step currently playing.
REQ-014 done  out  1  one-cycle pulse when playback ends without looping.

Function
REQ-015 The FSM shall have exactly these states: IDLE, FETCH, APPLY, HOLD.
REQ-016 IDLE shall respond to start by capturing cfg_reg_1/2/4 into reg_1/2/4, clearing step_idx to 0 and entering FETCH.
REQ-017 FETCH shall issue a registered table read for step_idx with 1-cycle read latency, then enter APPLY.
REQ-018 APPLY, when dur != 0, shall load reg_3 with pitch and reg_0[5:0] with vol, toggle reg_0[6], clear the tick counter and enter HOLD.
REQ-019 APPLY, when dur == 0, shall treat the step as the end-of-pattern marker; no register changes.
REQ-020 HOLD shall count tick strobes and leave on the tick that makes the count equal dur, so a step lasts exactly dur ticks; a tick in the APPLY cycle is not counted.
REQ-021 On leaving HOLD from step 15, or on reaching an end marker, playback ends; otherwise step_idx increments and the FSM enters FETCH.
REQ-022 At pattern end the FSM shall set reg_0[5:0]=0, pulse done and enter IDLE.
REQ-023 An end marker at step 0 (empty pattern) shall produce done two cycles after start, with reg_0[6] unchanged.
REQ-024 stop in any non-IDLE state shall force reg_0[5:0]=0 and enter IDLE next cycle, with no done pulse.
REQ-025 start and stop asserted in the same cycle: stop wins and start is ignored.
REQ-026 start while busy shall be ignored.
REQ-027 wr_ready shall equal !busy; wr_en while busy shall be dropped and the table left unchanged.
REQ-028 A write in the same cycle as start shall be accepted, and the playback that starts shall see the new data.
REQ-029 reg_1/2/4 shall hold their captured values until the next accepted start.

Reset
REQ-030 reset_n low shall force state=IDLE, reg_0..reg_4=8'h00, step_idx=0, busy=0, done=0, wr_ready=1 and the tick counter to 0.
REQ-031 Step-table contents shall not be reset; reset mid-playback shall silence the outputs immediately (asynchronously).

Configuration
REQ-032 Macro CHSEQ_LOOP_EN defined: at pattern end with loop_en=1, the FSM returns to FETCH with step_idx=0, no done pulse and no mute.
REQ-033 Macro CHSEQ_LOOP_EN undefined: the loop_en port shall exist but be ignored, and pattern end always behaves as in REQ-022.

Structure
REQ-034 Package chseq_pkg shall hold `CHSEQ_DEPTH`, the step_t packed struct (dur, pitch, rsvd, vol) and the state enum.
REQ-035 Sub-module chseq_step_ram (16x24, one write port, one registered read port) shall hold the step table; the FSM stays in channel_sequencer.

Verification
REQ-036 Write step0={dur=3, pitch=8'h42, vol=20}, step1 dur=0; start; 3 ticks -> reg_3=8'h42, reg_0[5:0]=20, reg_0[6] toggled once; done 1 cycle after the FSM leaves HOLD; reg_0[5:0]=0.
REQ-037 Write all 16 steps with dur=1 -> 16 reg_0[6] toggles, step_idx 0..15, done after the 16th tick (wrap path without an end marker).
REQ-038 stop on the 2nd tick of a dur=5 step -> IDLE next cycle, reg_0[5:0]=0, no done pulse; wr_en now accepted.
REQ-039 start+stop in the same cycle from IDLE -> busy stays 0; wr_en while busy with wr_data=24'hFFFFFF -> table read-back unchanged.
REQ-040 CHSEQ_LOOP_EN defined, loop_en=1, two-step pattern -> step_idx sequence 0,1,0,1, no done; repeated with the macro undefined -> done after step 1.
REQ-041 reset_n pulsed low mid-HOLD -> all outputs 0 immediately; re-played pattern behaves identically to REQ-036.

Source files
------------

// File: rtl/chseq_pkg.sv
// Shared types for channel_sequencer: step-table depth, step record layout, FSM states.
package chseq_pkg;

  localparam int CHSEQ_DEPTH = 16;
  localparam int CHSEQ_AW    = 4;

  typedef struct packed {
    logic [7:0] dur;
    logic [7:0] pitch;
    logic [1:0] rsvd;
    logic [5:0] vol;
  } step_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    APPLY = 2'd2,
    HOLD  = 2'd3
  } chseq_state_e;

endpackage

// File: rtl/channel_sequencer_if.sv
// Step-table write port bundle; the sequencer is the slave side.
interface channel_sequencer_if;
  import chseq_pkg::*;

  logic                wr_en;
  logic [CHSEQ_AW-1:0] wr_addr;
  logic [23:0]         wr_data;
  logic                wr_ready;

  modport master (output wr_en, wr_addr, wr_data, input  wr_ready);
  modport slave  (input  wr_en, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/chseq_step_ram.sv
// 16x24 step table: one write port, one registered read port (1-cycle latency).
module chseq_step_ram
  import chseq_pkg::*;
(
  input  logic                clk_50mhz,
  input  logic                we,
  input  logic [CHSEQ_AW-1:0] waddr,
  input  step_t               wdata,
  input  logic                re,
  input  logic [CHSEQ_AW-1:0] raddr,
  output step_t               rdata
);

  step_t mem [CHSEQ_DEPTH];

  // Contents and read register are deliberately not reset.
  always_ff @(posedge clk_50mhz) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/channel_sequencer.sv
// Step-table driven channel sequencer: plays steps on 8 kHz ticks into a register image.
// Build option: define CHSEQ_LOOP_EN to allow restarting the pattern when loop_en is high.
module channel_sequencer
  import chseq_pkg::*;
(
  input  logic                clk_50mhz,
  input  logic                reset_n,
  input  logic                tick,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  channel_sequencer_if.slave  wr,
  input  logic [7:0]          cfg_reg_1,
  input  logic [7:0]          cfg_reg_2,
  input  logic [7:0]          cfg_reg_4,
  output logic [7:0]          reg_0,
  output logic [7:0]          reg_1,
  output logic [7:0]          reg_2,
  output logic [7:0]          reg_3,
  output logic [7:0]          reg_4,
  output logic                busy,
  output logic [CHSEQ_AW-1:0] step_idx,
  output logic                done
);

  chseq_state_e state;
  logic [7:0]   tick_cnt;
  step_t        rd_step;
  logic         last_tick;
  logic         pat_end;
  logic         loop_go;
  logic         unused_rsvd;

  assign busy        = (state != IDLE);
  assign wr.wr_ready = ~busy;
  assign unused_rsvd = ^rd_step.rsvd;

`ifdef CHSEQ_LOOP_EN
  assign loop_go = loop_en;
`else
  logic unused_loop_en;
  assign unused_loop_en = loop_en;
  assign loop_go        = 1'b0;
`endif

  chseq_step_ram u_ram (
    .clk_50mhz (clk_50mhz),
    .we        (wr.wr_en & ~busy),
    .waddr     (wr.wr_addr),
    .wdata     (step_t'(wr.wr_data)),
    .re        (state == FETCH),
    .raddr     (step_idx),
    .rdata     (rd_step)
  );

  // rd_step stays stable through HOLD: reads only happen in FETCH and writes are blocked while busy.
  assign last_tick = tick && ((tick_cnt + 8'd1) == rd_step.dur);
  assign pat_end   = ((state == APPLY) && (rd_step.dur == 8'd0)) ||
                     ((state == HOLD) && last_tick && (step_idx == {CHSEQ_AW{1'b1}}));

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      reg_0    <= 8'h00;
      reg_1    <= 8'h00;
      reg_2    <= 8'h00;
      reg_3    <= 8'h00;
      reg_4    <= 8'h00;
      step_idx <= '0;
      tick_cnt <= 8'h00;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && busy) begin
        reg_0[5:0] <= 6'd0;
        state      <= IDLE;
      end else if (pat_end) begin
        if (loop_go) begin
          step_idx <= '0;
          state    <= FETCH;
        end else begin
          reg_0[5:0] <= 6'd0;
          done       <= 1'b1;
          state      <= IDLE;
        end
      end else begin
        case (state)
          IDLE: if (start && !stop) begin
            reg_1    <= cfg_reg_1;
            reg_2    <= cfg_reg_2;
            reg_4    <= cfg_reg_4;
            step_idx <= '0;
            state    <= FETCH;
          end
          FETCH: state <= APPLY;
          APPLY: begin
            reg_3      <= rd_step.pitch;
            reg_0[5:0] <= rd_step.vol;
            reg_0[6]   <= ~reg_0[6];
            tick_cnt   <= 8'h00;
            state      <= HOLD;
          end
          HOLD: begin
            if (last_tick) begin
              step_idx <= step_idx + 1'b1;
              state    <= FETCH;
            end else if (tick) begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
